// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: default geometry and Gray/binary conversions.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_W = 3;
  localparam int unsigned DEPTH       = 2 ** FIFO_ADDR_W;

  // Conversion functions work on a wide vector; callers zero-extend and truncate.
  localparam int unsigned FN_W = 32;

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b = '0;
    for (int i = 0; i < int'(FN_W); i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module fifo_gray2bin #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Bit i is the parity of gray[W-1:i].
  always_comb begin
    bin = '0;
    for (int i = 0; i < int'(W); i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer controller for the async FIFO: pointers, flags, level, underflow.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W    = FIFO_ADDR_W,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              r_clk,
  input  logic              r_rstn,
  input  logic              r_inc,
  input  logic              underflow_clr,
  input  logic [ADDR_W:0]   sync_wr_ptr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   gray_rd_ptr,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              rd_ack,
  output logic              underflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] rd_bin_nxt;
  logic [PTR_W-1:0] rd_gray_nxt;
  logic [PTR_W-1:0] wr_bin;
  logic [PTR_W-1:0] lvl_nxt;
  logic             acc;

  // Synchronised write pointer back to binary for the occupancy subtraction.
  fifo_gray2bin #(.W(PTR_W)) u_wr_g2b (
    .gray (sync_wr_ptr),
    .bin  (wr_bin)
  );

  // Next pointer and occupancy, both taken from post-read values.
  always_comb begin
    acc         = r_inc & ~empty;
    rd_bin_nxt  = rd_bin + PTR_W'(acc);
    rd_gray_nxt = PTR_W'(bin2gray(FN_W'(rd_bin_nxt)));
    lvl_nxt     = wr_bin - rd_bin_nxt;
  end

  assign rd_addr = rd_bin[ADDR_W-1:0];
  assign rd_ack  = acc;

  // Pointer, flag and level registers.
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      rd_bin       <= '0;
      gray_rd_ptr  <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
    end else begin
      rd_bin       <= rd_bin_nxt;
      gray_rd_ptr  <= rd_gray_nxt;
      empty        <= (rd_gray_nxt == sync_wr_ptr);
      almost_empty <= (lvl_nxt <= PTR_W'(AE_THRESH));
      rd_level     <= lvl_nxt;
    end
  end

  // Sticky underflow; a new underflow attempt beats a simultaneous clear.
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      underflow <= 1'b0;
    end else if (r_inc && empty) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl against a count-based FIFO model.
module tb_fifo_rd_ctrl;

  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned AE_THRESH = 2;

  logic       r_clk;
  logic       r_rstn;
  logic       r_inc;
  logic       underflow_clr;
  logic [3:0] sync_wr_ptr;
  logic [2:0] rd_addr;
  logic [3:0] gray_rd_ptr;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_level;
  logic       rd_ack;
  logic       underflow;

  int checks;
  int errors;

  // Model: total words written/read since reset, plus registered flag views.
  int wr_tot;
  int rd_tot;
  int m_level;
  bit m_empty;
  bit m_uf;
  bit exp_ack;
  bit obs_ack;
  logic [2:0] exp_addr;
  logic [2:0] obs_addr;

  fifo_rd_ctrl #(.ADDR_W(ADDR_W), .AE_THRESH(AE_THRESH)) dut (
    .r_clk         (r_clk),
    .r_rstn        (r_rstn),
    .r_inc         (r_inc),
    .underflow_clr (underflow_clr),
    .sync_wr_ptr   (sync_wr_ptr),
    .rd_addr       (rd_addr),
    .gray_rd_ptr   (gray_rd_ptr),
    .empty         (empty),
    .almost_empty  (almost_empty),
    .rd_level      (rd_level),
    .rd_ack        (rd_ack),
    .underflow     (underflow)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  // One clock: drive inputs, sample combinational outputs, update model, settle.
  task automatic cycle(input bit inc, input bit clr, input int wadd);
    r_inc         = inc;
    underflow_clr = clr;
    wr_tot        = wr_tot + wadd;
    sync_wr_ptr   = gray4(wr_tot);
    #1;
    exp_ack  = inc && !m_empty;
    exp_addr = 3'(rd_tot % 8);
    obs_ack  = rd_ack;
    obs_addr = rd_addr;
    @(posedge r_clk);
    if (exp_ack) rd_tot = rd_tot + 1;
    if (inc && m_empty) m_uf = 1'b1;
    else if (clr) m_uf = 1'b0;
    m_level = wr_tot - rd_tot;
    m_empty = (m_level == 0);
    #1;
  endtask

  task automatic model_reset();
    wr_tot = 0; rd_tot = 0; m_level = 0; m_empty = 1'b1; m_uf = 1'b0;
  endtask

  task automatic apply_reset();
    r_inc = 1'b0; underflow_clr = 1'b0; sync_wr_ptr = '0;
    r_rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge r_clk);
    @(negedge r_clk);
    r_rstn = 1'b1;
    @(posedge r_clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
    checks++; if (rd_level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", rd_level); end
    checks++; if (gray_rd_ptr !== 4'b0000) begin errors++; $display("FAIL reset_gray got=%b exp=0000", gray_rd_ptr); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_uf got=%b exp=0", underflow); end
    checks++; if (rd_addr !== 3'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", rd_addr); end
  endtask

  task automatic test_fill_drain();
    logic [3:0] g5;
    g5 = 4'b0111;
    cycle(1'b0, 1'b0, 5);
    checks++; if (sync_wr_ptr !== g5) begin errors++; $display("FAIL fill_gray5 got=%b exp=%b", sync_wr_ptr, g5); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty got=%b exp=0", empty); end
    checks++; if (rd_level !== 4'd5) begin errors++; $display("FAIL fill_level got=%0d exp=5", rd_level); end
    checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL fill_ae got=%b exp=0", almost_empty); end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 0);
      checks++; if (obs_addr !== 3'(i)) begin errors++; $display("FAIL drain_addr[%0d] got=%0d exp=%0d", i, obs_addr, i); end
      checks++; if (obs_ack !== 1'b1) begin errors++; $display("FAIL drain_ack[%0d] got=%b exp=1", i, obs_ack); end
      checks++; if (rd_level !== 4'(4 - i)) begin errors++; $display("FAIL drain_level[%0d] got=%0d exp=%0d", i, rd_level, 4 - i); end
      checks++; if (almost_empty !== ((4 - i) <= 2)) begin errors++; $display("FAIL drain_ae[%0d] got=%b", i, almost_empty); end
      checks++; if (empty !== (i == 4)) begin errors++; $display("FAIL drain_empty[%0d] got=%b", i, empty); end
    end
  endtask

  task automatic test_underflow();
    cycle(1'b1, 1'b0, 0);
    checks++; if (obs_ack !== 1'b0) begin errors++; $display("FAIL uf_ack got=%b exp=0", obs_ack); end
    checks++; if (rd_addr !== 3'd5) begin errors++; $display("FAIL uf_addr got=%0d exp=5", rd_addr); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set got=%b exp=1", underflow); end
    cycle(1'b0, 1'b0, 0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_hold got=%b exp=1", underflow); end
    cycle(1'b1, 1'b1, 0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins got=%b exp=1", underflow); end
    cycle(1'b0, 1'b1, 0);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got=%b exp=0", underflow); end
  endtask

  task automatic test_wrap();
    logic [3:0] g8;
    g8 = 4'b1100;
    apply_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 0);
      checks++; if (rd_addr !== 3'd0) begin errors++; $display("FAIL wrap_addr[%0d] got=%0d exp=0", pass, rd_addr); end
      checks++; if (gray_rd_ptr !== ((pass == 0) ? g8 : 4'b0000)) begin errors++; $display("FAIL wrap_gray[%0d] got=%b", pass, gray_rd_ptr); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty[%0d] got=%b exp=1", pass, empty); end
    end
  endtask

  task automatic test_full_level();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1);
    checks++; if (sync_wr_ptr !== 4'b1100) begin errors++; $display("FAIL full_sync got=%b exp=1100", sync_wr_ptr); end
    checks++; if (rd_level !== 4'd8) begin errors++; $display("FAIL full_level got=%0d exp=8", rd_level); end
    checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL full_ae got=%b exp=0", almost_empty); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL full_empty got=%b exp=0", empty); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 0);
    checks++; if (rd_level !== 4'd4) begin errors++; $display("FAIL simul_pre got=%0d exp=4", rd_level); end
    cycle(1'b1, 1'b0, 1);
    checks++; if (obs_ack !== 1'b1) begin errors++; $display("FAIL simul_ack got=%b exp=1", obs_ack); end
    checks++; if (rd_level !== 4'd4) begin errors++; $display("FAIL simul_level got=%0d exp=4", rd_level); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL simul_empty got=%b exp=0", empty); end
    // Async reset mid-burst, sampled before any further clock edge.
    r_inc = 1'b1;
    #2;
    r_rstn = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL areset_empty got=%b exp=1", empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL areset_ae got=%b exp=1", almost_empty); end
    checks++; if (rd_level !== 4'd0) begin errors++; $display("FAIL areset_level got=%0d exp=0", rd_level); end
    checks++; if (gray_rd_ptr !== 4'd0) begin errors++; $display("FAIL areset_gray got=%b exp=0000", gray_rd_ptr); end
    checks++; if (rd_addr !== 3'd0) begin errors++; $display("FAIL areset_addr got=%0d exp=0", rd_addr); end
    checks++; if (rd_ack !== 1'b0) begin errors++; $display("FAIL areset_ack got=%b exp=0", rd_ack); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL areset_uf got=%b exp=0", underflow); end
    apply_reset();
  endtask

  task automatic test_random();
    bit inc, clr;
    int wadd;
    for (int n = 0; n < 400; n++) begin
      inc  = ($urandom_range(0, 99) < 55);
      clr  = ($urandom_range(0, 3) == 0);
      wadd = ((wr_tot - rd_tot) < 8 && $urandom_range(0, 1) == 1) ? 1 : 0;
      cycle(inc, clr, wadd);
      checks++; if (obs_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack[%0d] got=%b exp=%b", n, obs_ack, exp_ack); end
      checks++; if (obs_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr[%0d] got=%0d exp=%0d", n, obs_addr, exp_addr); end
      checks++; if (rd_level !== 4'(m_level)) begin errors++; $display("FAIL rnd_level[%0d] got=%0d exp=%0d", n, rd_level, m_level); end
      checks++; if (empty !== m_empty) begin errors++; $display("FAIL rnd_empty[%0d] got=%b exp=%b", n, empty, m_empty); end
      checks++; if (almost_empty !== (m_level <= int'(AE_THRESH))) begin errors++; $display("FAIL rnd_ae[%0d] got=%b lvl=%0d", n, almost_empty, m_level); end
      checks++; if (gray_rd_ptr !== gray4(rd_tot)) begin errors++; $display("FAIL rnd_gray[%0d] got=%b exp=%b", n, gray_rd_ptr, gray4(rd_tot)); end
      checks++; if (underflow !== m_uf) begin errors++; $display("FAIL rnd_uf[%0d] got=%b exp=%b", n, underflow, m_uf); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    r_rstn = 1'b0;
    r_inc = 1'b0;
    underflow_clr = 1'b0;
    sync_wr_ptr = '0;
    model_reset();
    test_reset();
    test_fill_drain();
    test_underflow();
    test_wrap();
    test_full_level();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
